aes_core: RTL and testbench

`aes_core` performs the AES SubBytes transformation (FIPS-197 §5.1.1) on a full 128-bit state block. Each of the 16 bytes is replaced by its forward S-box value. It is the byte-substitution stage of the AES encryption datapath. In the default build it is purely combinational; a build option adds an output register.

---
 rtl/aes_core.sv | 52 +++++
 tb/tb_aes_core.sv | 138 +++++++++++++
 2 files changed

// File: rtl/aes_core.sv
// AES SubBytes on a full 128-bit state: 16 parallel forward S-box lookups.
// Define AES_CORE_OUT_REG_EN to register the output (1-cycle latency, sync active-low clear).
module aes_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] block,
   output logic [127:0] new_block
);

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [0:255][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[b];
   endfunction

   logic [127:0] sub;

   for (genvar k = 0; k < 16; k++) begin : g_byte
      assign sub[127-8*k -: 8] = sbox(block[127-8*k -: 8]);
   end

`ifdef AES_CORE_OUT_REG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) new_block <= 128'h0;
      else        new_block <= sub;
   end
`else
   // Clock and reset are intentionally unused in the combinational build.
   logic unused_ctrl;
   assign unused_ctrl = clk ^ rst_n;
   assign new_block   = sub;
`endif

endmodule

// File: tb/tb_aes_core.sv
// Scoreboard bench for aes_core; reference S-box derived from GF(2^8) inversion plus affine map.
// Works in both the default build and with AES_CORE_OUT_REG_EN defined.
module tb_aes_core;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] block = 128'h0;
   logic [127:0] new_block;

   int total = 0;
   int bad   = 0;

   logic [127:0] exp_q[$];
   string        name_q[$];
   logic [7:0]   ref_tab[256];

   aes_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .block     (block),
      .new_block (new_block)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rol(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // inverse = x^254 (gives 0 for 0), then the FIPS-197 affine transform.
   function automatic logic [7:0] model_sbox(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      return inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] ref_sub(input logic [127:0] b);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[127-8*k -: 8] = ref_tab[b[127-8*k -: 8]];
      return r;
   endfunction

   task automatic drive(input logic [127:0] b, input logic r, input logic [127:0] e, input string nm);
      @(posedge clk);
      #1;
      block = b;
      rst_n = r;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic apply_model(input logic [127:0] b, input logic r, input string nm);
`ifdef AES_CORE_OUT_REG_EN
      drive(b, r, r ? ref_sub(b) : 128'h0, nm);
`else
      drive(b, r, ref_sub(b), nm);
`endif
   endtask

   // Monitor: every cycle is valid, so one expected entry is retired per cycle.
   initial begin
      logic [127:0] e;
      string        n;
      int           avail;
      forever begin
`ifdef AES_CORE_OUT_REG_EN
         @(posedge clk);
         avail = exp_q.size();
         #2;
`else
         @(negedge clk);
         avail = exp_q.size();
`endif
         if (avail > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if (new_block !== e) begin
               bad++;
               $display("FAIL %s: new_block=%h expected=%h", n, new_block, e);
            end
         end
      end
   end

   initial begin
      logic [127:0] rb;
      logic [7:0]   v;
      for (int i = 0; i < 256; i++) ref_tab[i] = model_sbox(i[7:0]);

      apply_model(128'h0, 1'b0, "reset_state");
      drive(128'h0, 1'b1, {16{8'h63}}, "reset_release_zero");
      drive(128'h19a09ae9_3df4c6f8_e3e28d48_be2b2a08, 1'b1,
            128'hd4e0b81e_27bfb441_11985d52_aef1e530, "fips197_vector");
      drive({16{8'hff}}, 1'b1, {16{8'h16}}, "all_ff");
      drive({16{8'h01}}, 1'b1, {16{8'h7c}}, "all_01");
      drive(128'h53000000_00000000_00000000_00000010, 1'b1,
            128'hed636363_63636363_63636363_636363ca, "byte_independence");

      for (int i = 0; i < 256; i++) begin
         v = i[7:0];
         apply_model({16{v}}, 1'b1, $sformatf("sweep_%02h", v));
      end

      for (int i = 0; i < 10; i++) begin
         rb = {$urandom, $urandom, $urandom, $urandom};
         apply_model(rb, 1'b1, $sformatf("random_%0d", i));
      end

      // Random stream with a one-cycle reset pulse in the middle.
      for (int i = 0; i < 16; i++) begin
         rb = {$urandom, $urandom, $urandom, $urandom};
         apply_model(rb, (i == 7) ? 1'b0 : 1'b1, $sformatf("stream_%0d", i));
      end

      repeat (4) @(posedge clk);
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
